// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: default widths, funct3 access codes,
// FSM state encoding and the access-size helper.
package mem_access_pkg;

   localparam int DEF_ADDR_LEN     = 32;
   localparam int DEF_REG_LEN      = 32;
   localparam int DEF_REG_ADDR_LEN = 5;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ACCESS    = 2'd1,
      ST_WAIT_LAST = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   // Index of the last byte of an access: 0 for byte, 1 for half, 3 otherwise.
   function automatic logic [1:0] last_byte_idx(input logic [1:0] size);
      case ({1'b0, size})
         F3_SB:   return 2'd0;
         F3_SH:   return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// Byte-wide memory-controller port between the MEM stage (master) and the controller (slave).
interface mem_access_if #(
   parameter int ADDR_LEN = 32
);
   // Handshake: a byte transfers in any cycle with mem_req && mem_grant. While mem_req is
   // high without mem_grant, mem_wr/mem_addr/mem_wdata stay stable. For reads, mem_rdata is
   // valid in the cycle after the accepting grant.
   logic                mem_req;
   logic                mem_wr;
   logic [ADDR_LEN-1:0] mem_addr;
   logic [7:0]          mem_wdata;
   logic                mem_grant;
   logic [7:0]          mem_rdata;

   modport master (
      output mem_req, mem_wr, mem_addr, mem_wdata,
      input  mem_grant, mem_rdata
   );

   modport slave (
      input  mem_req, mem_wr, mem_addr, mem_wdata,
      output mem_grant, mem_rdata
   );

endinterface

// File: rtl/mem_access_load_extend.sv
// Sign/zero extension of an assembled load word according to funct3.
module mem_access_load_extend
   import mem_access_pkg::*;
#(
   parameter int REG_LEN = DEF_REG_LEN
) (
   input  logic [REG_LEN-1:0] raw,
   input  logic [2:0]         funct3,
   output logic [REG_LEN-1:0] result
);

   always_comb begin
      result = raw;
      case (funct3)
         F3_LB:   result = {{(REG_LEN-8){raw[7]}}, raw[7:0]};
         F3_LBU:  result = {{(REG_LEN-8){1'b0}}, raw[7:0]};
         F3_LH:   result = {{(REG_LEN-16){raw[15]}}, raw[15:0]};
         F3_LHU:  result = {{(REG_LEN-16){1'b0}}, raw[15:0]};
         F3_LW:   result = raw;
         default: result = raw;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: serves loads/stores byte-serially over the memory-controller port,
// passes non-memory results through, and stalls the pipeline while an access runs.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int ADDR_LEN     = DEF_ADDR_LEN,
   parameter int REG_LEN      = DEF_REG_LEN,
   parameter int REG_ADDR_LEN = DEF_REG_ADDR_LEN
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_enable_i,
   input  logic                    store_enable_i,
   input  logic [ADDR_LEN-1:0]     load_store_addr_i,
   input  logic [2:0]              funct3_i,
   input  logic [REG_LEN-1:0]      store_data_i,
   input  logic [REG_LEN-1:0]      rd_data_i,
   input  logic [REG_ADDR_LEN-1:0] rd_addr_i,
   input  logic                    rd_write_enable_i,
   mem_access_if.master            mem,
   output logic [REG_LEN-1:0]      rd_data_o,
   output logic [REG_ADDR_LEN-1:0] rd_addr_o,
   output logic                    rd_write_enable_o,
   output logic                    stall_req_o,
   output state_t                  state_o
);

   state_t                  state;
   logic                    is_store_q;
   logic [ADDR_LEN-1:0]     base_q;
   logic [2:0]              funct3_q;
   logic [REG_LEN-1:0]      store_data_q;
   logic [REG_ADDR_LEN-1:0] rd_addr_q;
   logic                    we_q;
   logic [1:0]              issue_cnt;
   logic [1:0]              recv_cnt;
   logic                    rx_pending;
   logic [REG_LEN-1:0]      word_q;
   logic [REG_LEN-1:0]      load_result;
   logic                    start;
   logic [1:0]              last_idx;

   assign start    = load_enable_i | store_enable_i;
   assign last_idx = last_byte_idx(funct3_q[1:0]);
   assign state_o  = state;

   mem_access_load_extend #(
      .REG_LEN (REG_LEN)
   ) u_load_extend (
      .raw    (word_q),
      .funct3 (funct3_q),
      .result (load_result)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         is_store_q   <= 1'b0;
         base_q       <= '0;
         funct3_q     <= '0;
         store_data_q <= '0;
         rd_addr_q    <= '0;
         we_q         <= 1'b0;
         issue_cnt    <= '0;
         recv_cnt     <= '0;
         rx_pending   <= 1'b0;
         word_q       <= '0;
      end else begin
         // A read byte arrives one cycle after its grant, whatever the state is by then.
         rx_pending <= 1'b0;
         if (rx_pending) begin
            word_q[{recv_cnt, 3'b000} +: 8] <= mem.mem_rdata;
            recv_cnt                        <= recv_cnt + 2'd1;
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  is_store_q   <= store_enable_i & ~load_enable_i;
                  base_q       <= load_store_addr_i;
                  funct3_q     <= funct3_i;
                  store_data_q <= store_data_i;
                  rd_addr_q    <= rd_addr_i;
                  we_q         <= rd_write_enable_i;
                  issue_cnt    <= '0;
                  recv_cnt     <= '0;
                  word_q       <= '0;
                  state        <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (mem.mem_grant) begin
                  issue_cnt  <= issue_cnt + 2'd1;
                  rx_pending <= ~is_store_q;
                  if (issue_cnt == last_idx) begin
                     state <= is_store_q ? ST_DONE : ST_WAIT_LAST;
                  end
               end
            end
            ST_WAIT_LAST: state <= ST_DONE;
            ST_DONE:      state <= ST_IDLE;
            default:      state <= ST_IDLE;
         endcase
      end
   end

   // Outputs are forced to zero while rst_n is low so an abort is visible immediately.
   always_comb begin
      mem.mem_req       = 1'b0;
      mem.mem_wr        = 1'b0;
      mem.mem_addr      = '0;
      mem.mem_wdata     = '0;
      rd_data_o         = '0;
      rd_addr_o         = '0;
      rd_write_enable_o = 1'b0;
      stall_req_o       = 1'b0;
      if (rst_n) begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  stall_req_o = 1'b1;
               end else begin
                  rd_data_o         = rd_data_i;
                  rd_addr_o         = rd_addr_i;
                  rd_write_enable_o = rd_write_enable_i;
               end
            end
            ST_ACCESS: begin
               stall_req_o   = 1'b1;
               mem.mem_req   = 1'b1;
               mem.mem_wr    = is_store_q;
               mem.mem_addr  = base_q + ADDR_LEN'(issue_cnt);
               mem.mem_wdata = store_data_q[{issue_cnt, 3'b000} +: 8];
            end
            ST_WAIT_LAST: stall_req_o = 1'b1;
            ST_DONE: begin
               rd_addr_o = rd_addr_q;
               if (!is_store_q) begin
                  rd_data_o         = load_result;
                  rd_write_enable_o = we_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
